// File: rtl/alu_pkg.sv
// alu_pkg: ALU control codes and arbiter FSM state type
package alu_pkg;
  localparam logic [2:0] ALU_AND  = 3'b000;
  localparam logic [2:0] ALU_OR   = 3'b001;
  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_NOP  = 3'b011;
  localparam logic [2:0] ALU_BGTZ = 3'b100;
  localparam logic [2:0] ALU_SUB  = 3'b110;
  localparam logic [2:0] ALU_SLT  = 3'b111;
  typedef enum logic [1:0] {IDLE, EXEC, RESP} arb_state_t;
endpackage

// File: rtl/alu_arbiter_alu.sv
// ALU: 32-bit combinational ALU with zero flag
module ALU
  import alu_pkg::*;
(
  input  logic [31:0] Op1,
  input  logic [31:0] Op2,
  input  logic [2:0]  ALUCtl,
  output logic [31:0] Res,
  output logic        ZF
);
  // Operation select; NOP and the unused code fall through to zero
  always_comb begin
    Res = (ALUCtl == ALU_AND)  ? Op1 & Op2 :
          (ALUCtl == ALU_OR)   ? Op1 | Op2 :
          (ALUCtl == ALU_ADD)  ? Op1 + Op2 :
          (ALUCtl == ALU_SUB)  ? Op1 - Op2 :
          (ALUCtl == ALU_SLT)  ? {31'b0, Op1 < Op2} :
          (ALUCtl == ALU_BGTZ) ? {31'b0, $signed(Op1) > 32'sd0} : 32'b0;
    ZF = (Res == 32'b0);
  end
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one ALU between two requesters
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ReqValid0,
  input  logic         ReqValid1,
  output logic         ReqReady0,
  output logic         ReqReady1,
  input  logic [W-1:0] Op1_0,
  input  logic [W-1:0] Op2_0,
  input  logic [W-1:0] Op1_1,
  input  logic [W-1:0] Op2_1,
  input  logic [2:0]   Ctl0,
  input  logic [2:0]   Ctl1,
  output logic         RespValid0,
  output logic         RespValid1,
  input  logic         RespReady0,
  input  logic         RespReady1,
  output logic [W-1:0] RespRes,
  output logic         RespZF,
  output logic         Busy
);
  arb_state_t r_state, w_next;
  // r_last is both the round-robin pointer and the id of the port in flight,
  // since it updates on every accept and nothing else is accepted until IDLE
  logic         r_last;
  logic [W-1:0] r_op1, r_op2;
  logic [2:0]   r_ctl;
  logic         r_zf;
  logic [W-1:0] r_res;
  logic         w_sel, w_idle, w_accept, w_zf;
  logic [W-1:0] w_res;
  assign w_idle     = (r_state == IDLE);
  assign w_sel      = (ReqValid0 & ReqValid1) ? ~r_last : ReqValid1;
  assign w_accept   = w_idle & (ReqValid0 | ReqValid1);
  assign ReqReady0  = w_idle & ReqValid0 & ~w_sel;
  assign ReqReady1  = w_idle & ReqValid1 & w_sel;
  assign RespValid0 = (r_state == RESP) & ~r_last;
  assign RespValid1 = (r_state == RESP) & r_last;
  assign RespRes    = r_res;
  assign RespZF     = r_zf;
  assign Busy       = ~w_idle;
  ALU u_alu (
    .Op1   (r_op1),
    .Op2   (r_op2),
    .ALUCtl(r_ctl),
    .Res   (w_res),
    .ZF    (w_zf)
  );
  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end
  // Next state: accept in IDLE, one execute cycle, wait for the owner's ready
  always_comb begin
    w_next = IDLE;
    case (r_state)
      IDLE:    w_next = w_accept ? EXEC : IDLE;
      EXEC:    w_next = RESP;
      RESP:    w_next = (r_last ? RespReady1 : RespReady0) ? IDLE : RESP;
      default: w_next = IDLE;
    endcase
  end
  // Capture the granted request and register the ALU result in EXEC
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= 1'b1;
      r_op1  <= '0;
      r_op2  <= '0;
      r_ctl  <= ALU_NOP;
      r_res  <= '0;
      r_zf   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_last <= w_sel;
        r_op1  <= w_sel ? Op1_1 : Op1_0;
        r_op2  <= w_sel ? Op2_1 : Op2_0;
        r_ctl  <= w_sel ? Ctl1 : Ctl0;
      end
      if (r_state == EXEC) begin
        r_res <= w_res;
        r_zf  <= w_zf;
      end
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: randomized and directed checks against a behavioural model
module tb_alu_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ReqValid0 = 1'b0, ReqValid1 = 1'b0;
  logic        ReqReady0, ReqReady1;
  logic [31:0] Op1_0 = '0, Op2_0 = '0, Op1_1 = '0, Op2_1 = '0;
  logic [2:0]  Ctl0 = '0, Ctl1 = '0;
  logic        RespValid0, RespValid1;
  logic        RespReady0 = 1'b0, RespReady1 = 1'b0;
  logic [31:0] RespRes;
  logic        RespZF, Busy;
  int          total = 0;
  int          bad = 0;
  logic        mlast = 1'b1;

  always #5 clk = ~clk;

  alu_arbiter #(.W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .ReqValid0(ReqValid0), .ReqValid1(ReqValid1),
    .ReqReady0(ReqReady0), .ReqReady1(ReqReady1),
    .Op1_0(Op1_0), .Op2_0(Op2_0), .Op1_1(Op1_1), .Op2_1(Op2_1),
    .Ctl0(Ctl0), .Ctl1(Ctl1),
    .RespValid0(RespValid0), .RespValid1(RespValid1),
    .RespReady0(RespReady0), .RespReady1(RespReady1),
    .RespRes(RespRes), .RespZF(RespZF), .Busy(Busy)
  );

  function automatic logic [31:0] ref_alu(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
    case (c)
      3'd0:    return a & b;
      3'd1:    return a | b;
      3'd2:    return a + b;
      3'd6:    return a - b;
      3'd7:    return (a < b) ? 32'd1 : 32'd0;
      3'd4:    return (int'(a) > 0) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic txn(input logic v0, input logic [2:0] c0, input logic [31:0] a0, input logic [31:0] b0,
                     input logic v1, input logic [2:0] c1, input logic [31:0] a1, input logic [31:0] b1);
    logic g;
    logic [31:0] r;
    g = (v0 && v1) ? ~mlast : v1;
    r = g ? ref_alu(c1, a1, b1) : ref_alu(c0, a0, b0);
    @(negedge clk);
    ReqValid0 = v0; Ctl0 = c0; Op1_0 = a0; Op2_0 = b0;
    ReqValid1 = v1; Ctl1 = c1; Op1_1 = a1; Op2_1 = b1;
    RespReady0 = 1'b1; RespReady1 = 1'b1;
    #1;
    chk("busy_idle", Busy, 0);
    chk("req_ready0", ReqReady0, v0 && !g);
    chk("req_ready1", ReqReady1, v1 && g);
    @(negedge clk);
    ReqValid0 = 1'b0; ReqValid1 = 1'b0;
    #1;
    chk("busy_exec", Busy, 1);
    chk("resp_valid_exec", {RespValid1, RespValid0}, 0);
    chk("req_ready_exec", {ReqReady1, ReqReady0}, 0);
    @(negedge clk);
    #1;
    chk("resp_valid0", RespValid0, !g);
    chk("resp_valid1", RespValid1, g);
    chk("resp_res", RespRes, r);
    chk("resp_zf", RespZF, r == 0);
    mlast = g;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_busy", Busy, 0);
    chk("rst_res", RespRes, 0);
    @(negedge clk);
    rst_n = 1'b1;
    mlast = 1'b1;
  endtask

  initial begin
    #1;
    chk("por_resp_valid", {RespValid1, RespValid0}, 0);
    chk("por_res", RespRes, 0);
    chk("por_zf", RespZF, 0);
    chk("por_busy", Busy, 0);
    @(negedge clk);
    rst_n = 1'b1;

    txn(1, 3'b010, 5, 7, 0, 3'b000, 0, 0);

    do_reset();
    for (int i = 0; i < 4; i++) txn(1, 3'b010, i, 3, 1, 3'b110, 9, 9);

    txn(0, 0, 0, 0, 1, 3'b100, 32'hFFFF_FFFF, 0);
    txn(0, 0, 0, 0, 1, 3'b100, 1, 0);
    txn(1, 3'b111, 32'hFFFF_FFFF, 1, 0, 0, 0, 0);
    txn(1, 3'b101, 3, 4, 0, 0, 0, 0);
    txn(1, 3'b011, 3, 4, 1, 3'b000, 32'hF0F0, 32'h0FF0);
    txn(1, 3'b001, 32'h10, 32'h01, 1, 3'b111, 1, 2);

    @(negedge clk);
    ReqValid0 = 1'b1; Ctl0 = 3'b010; Op1_0 = 100; Op2_0 = 23;
    RespReady0 = 1'b0; RespReady1 = 1'b0;
    #1;
    chk("bp_ready0", ReqReady0, 1);
    @(negedge clk);
    ReqValid0 = 1'b0;
    ReqValid1 = 1'b1; Ctl1 = 3'b001; Op1_1 = 32'hA0; Op2_1 = 32'h05;
    RespReady1 = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_res_stable", RespRes, 123);
      chk("bp_valid0", RespValid0, 1);
      chk("bp_valid1", RespValid1, 0);
      chk("bp_ready1", ReqReady1, 0);
      @(negedge clk);
    end
    RespReady0 = 1'b1;
    #1;
    chk("bp_last_resp", RespValid0, 1);
    @(negedge clk);
    #1;
    chk("bp_idle_busy", Busy, 0);
    chk("bp_grant1", ReqReady1, 1);
    chk("bp_grant0", ReqReady0, 0);
    @(negedge clk);
    ReqValid1 = 1'b0;
    @(negedge clk);
    #1;
    chk("bp_p1_valid", RespValid1, 1);
    chk("bp_p1_res", RespRes, 32'hA5);
    mlast = 1'b1;

    @(negedge clk);
    ReqValid0 = 1'b1; Ctl0 = 3'b010; Op1_0 = 1; Op2_0 = 1;
    @(negedge clk);
    ReqValid0 = 1'b0;
    #1;
    chk("rx_busy_exec", Busy, 1);
    rst_n = 1'b0;
    #1;
    chk("rx_resp_valid", {RespValid1, RespValid0}, 0);
    chk("rx_res", RespRes, 0);
    chk("rx_zf", RespZF, 0);
    chk("rx_busy", Busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    mlast = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      chk("rx_no_replay", {Busy, RespValid1, RespValid0}, 0);
    end

    for (int i = 0; i < 40; i++) begin
      logic [1:0]  k;
      logic [31:0] a0, b0, a1, b1;
      k = 2'($urandom_range(1, 3));
      a0 = $urandom; a1 = $urandom;
      b0 = ($urandom_range(0, 3) == 0) ? a0 : $urandom;
      b1 = ($urandom_range(0, 3) == 0) ? a1 : $urandom;
      txn(k[0], 3'($urandom_range(0, 7)), a0, b0, k[1], 3'($urandom_range(0, 7)), a1, b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single combinational `ALU` instance between two requesters, the main datapath (port 0) and the branch/compare unit (port 1). Each requester issues operands plus a 3-bit ALU control code with a valid/ready handshake. The block registers the accepted operation, evaluates it through `ALU` in a dedicated execute cycle, and returns `Res`/`ZF` to the granting port only. Arbitration is round-robin with one transaction in flight.

## Interface
Parameters:
- `W`, 32, operand/result width; only 32 is supported, because `ALU` is fixed at 32 bits.

Ports:
- `clk` in 1: single clock; all state changes on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `ReqValid0`, `ReqValid1` in 1: request present on port 0 / port 1.
- `ReqReady0`, `ReqReady1` out 1: grant; the request is accepted on the edge where Valid&Ready.
- `Op1_0`, `Op2_0`, `Op1_1`, `Op2_1` in W: operands per port.
- `Ctl0`, `Ctl1` in 3: ALU control code per port (AND 000, OR 001, ADD 010, NOP 011, BGTZ 100, SUB 110, SLT 111).
- `RespValid0`, `RespValid1` out 1: result available for port 0 / port 1.
- `RespReady0`, `RespReady1` in 1: the port consumes its result.
- `RespRes` out W: registered ALU result, shared bus.
- `RespZF` out 1: registered zero flag, shared bus.
- `Busy` out 1: high in EXEC or RESP.

## Operation
- FSM states and transitions:
  - IDLE: when at least one ReqValid is high, grant one port, capture that port's Op1/Op2/Ctl and the port id, then go to EXEC.
  - EXEC: drive the captured operands into `ALU`, register `Res` and `ZF`, then go to RESP.
  - RESP: hold `RespValid` for the captured port; on `RespReady` of that port, go to IDLE.
- Ready generation:
  - `ReqReady*` is combinational and high only in IDLE, for the selected port only.
  - At most one `ReqReady` is high in any cycle.
  - `ReqReady` may depend on `ReqValid`.
- Round-robin:
  - A 1-bit `Last` pointer records the last granted port.
  - If both ports request in IDLE, grant `~Last`. If only one requests, grant it.
  - `Last` updates on every accept.
- Routing:
  - `RespRes` and `RespZF` are stable throughout RESP.
  - `RespValid` of the non-granted port stays 0.
  - `RespReady` of the non-granted port is ignored.
- Arithmetic is exactly that of `ALU`:
  - wrap-around ADD/SUB;
  - SLT is unsigned compare;
  - BGTZ is signed `Op1 > 0`;
  - NOP, and the unused code 101, give `Res` = 0 with `ZF` = 1.
- Requests not accepted are not queued. The requester must hold Valid and its operands stable until Ready.

## Timing
- Reset values:
  - state IDLE, `Last` = 1 (port 0 wins the first tie);
  - `RespValid0/1` = 0;
  - `RespRes` = 0, `RespZF` = 0;
  - `Busy` = 0;
  - `ReqReady*` follow the IDLE rule immediately after reset.
- Latency: handshake in cycle N; EXEC in N+1; `RespValid` high from N+2.
- Minimum spacing between accepts is 3 cycles (IDLE, EXEC, RESP with `RespReady` already high).
- `RespReady` held high while entering RESP: the response completes in that single RESP cycle, and the block is in IDLE the next cycle.
- A new request arriving during EXEC or RESP waits and is arbitrated in the next IDLE.
- `rst_n` asserted mid-EXEC or mid-RESP: the transaction is dropped, all outputs go to their reset values asynchronously, and the operation is not replayed.
- Deassertion of `rst_n` is synchronised externally. The block samples nothing on the first edge other than IDLE arbitration.

## Structure
- `alu_pkg` holds:
  - `localparam`s for the ALU control codes (`ALU_AND` … `ALU_SLT`);
  - the FSM state enum `arb_state_t` {IDLE, EXEC, RESP}.
- Sub-module: exactly one instance of the existing `ALU`. Everything else is inline: capture registers, FSM, round-robin pointer, response registers.
- No other sub-modules.

## Test plan
- Reset, then port 0 requests ADD 5+7:
  - `ReqReady0` is high in the same cycle;
  - `RespValid0` is high 2 cycles later with `RespRes` = 12, `ZF` = 0;
  - `RespValid1` stays 0.
- Both ports request simultaneously, repeatedly:
  - grants are 0, 1, 0, 1;
  - port 1 SUB 9-9 returns `Res` = 0, `ZF` = 1 on `RespValid1`.
- Port 1 BGTZ with `Op1` = 0xFFFFFFFF returns `Res` = 0. Then with `Op1` = 1, it returns `Res` = 1.
- SLT `Op1` = 0xFFFFFFFF, `Op2` = 1 returns `Res` = 0 (unsigned). Ctl 101 returns `Res` = 0, `ZF` = 1.
- Back-pressure: hold `RespReady0` low for 5 cycles while port 1 requests.
  - `RespRes` stays stable and `ReqReady1` stays 0 throughout.
  - Once `RespReady0` rises, port 1 is granted in the following IDLE cycle.
- Assert `rst_n` low during EXEC:
  - all outputs return to their reset values immediately;
  - no `RespValid` appears after release.
